// File: rtl/spi_target_rx_if.sv
// Received-word stream from the PMD901 SPI target receiver: valid/ready data slot plus
// frame status flags. The receiver drives the master side; the consumer takes the slave side.
interface spi_target_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  busy;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output rx_data, rx_valid, busy, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, busy, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/spi_target_rx.sv
// PMD901 SPI receive end: oversamples sclk/cs_n/mosi in PCLK, rebuilds MSB-first frames
// and hands good words to a single-entry valid/ready slot, flagging framing and overrun errors.
module spi_target_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  spi_target_rx_if.master  rx
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   p_sclk;
  logic                   p_cs_n;

  logic s_sclk;
  logic s_cs_n;
  logic s_mosi;
  logic sclk_rise;
  logic cs_fall;
  logic cs_rise;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  busy_q;
  logic                  frame_err_q;
  logic                  overrun_q;

  // Equal-length chains on all three pins keep mosi aligned with the sclk edge that samples it.
  // The chains reset to the bus idle levels so no false edge appears on reset release.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      p_sclk    <= 1'b0;
      p_cs_n    <= 1'b1;
    end else begin
      // NOTE: non-blocking shifts so every stage takes its neighbour's value from before this edge.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      p_sclk    <= sclk_sync[SYNC_STAGES-1];
      p_cs_n    <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign s_sclk    = sclk_sync[SYNC_STAGES-1];
  assign s_cs_n    = cs_sync[SYNC_STAGES-1];
  assign s_mosi    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~p_sclk;
  assign cs_fall   = ~s_cs_n & p_cs_n;
  assign cs_rise   = s_cs_n & ~p_cs_n;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // NOTE: a later assignment in this block overrides this clear, which is how a same-cycle
      // accept and new-word load leaves rx_valid high.
      if (rx_valid_q && rx.rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= RECV;
            busy_q  <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
          end
        end

        RECV: begin
          // A sclk rise coinciding with the end of the frame does not count as a bit.
          if (cs_rise) begin
            state  <= DONE;
            busy_q <= 1'b0;
          end else if (sclk_rise) begin
            shift <= {shift[DATA_WIDTH-2:0], s_mosi};
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          if (bit_cnt == CNT_FULL) begin
            if (!rx_valid_q || rx.rx_ready) begin
              rx_data_q  <= shift;
              rx_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            frame_err_q <= 1'b1;
          end

          if (cs_fall) begin
            state   <= RECV;
            busy_q  <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_valid  = rx_valid_q;
  assign rx.busy      = busy_q;
  assign rx.frame_err = frame_err_q;
  assign rx.overrun   = overrun_q;

endmodule

// File: tb/tb_spi_target_rx.sv
// Self-checking bench for spi_target_rx: directed frame table, hand-timed corner sequences
// and a randomized run scored against a frame-level model of the receiver.
module tb_spi_target_rx;

  localparam int W = 16;

  logic PCLK;
  logic PRESETn;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic ready_dir;
  logic rand_en;
  logic rand_bit;

  spi_target_rx_if #(.DATA_WIDTH(W)) rx_if ();

  assign rx_if.rx_ready = rand_en ? rand_bit : ready_dir;

  spi_target_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .rx     (rx_if)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Consumer-side monitor: records every accepted word and counts status pulses.
  logic [W-1:0] got_q[$];
  int           ferr_cnt = 0;
  int           ovr_cnt  = 0;
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always begin
    @(negedge PCLK);
    #1;
    if (rx_if.frame_err === 1'b1) ferr_cnt++;
    if (rx_if.overrun === 1'b1) ovr_cnt++;
    if (prev_valid && !prev_ready && rx_if.rx_valid && PRESETn)
      check("rx_data stable while held", 32'(rx_if.rx_data), 32'(prev_data));
    if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
    prev_valid = rx_if.rx_valid;
    prev_ready = rx_if.rx_ready;
    prev_data  = rx_if.rx_data;
  end

  always begin
    @(negedge PCLK);
    rand_bit = 1'($urandom_range(0, 1));
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // Drives one cs_n frame with nbits sclk pulses, shifting word[nbits-1:0] MSB first.
  task automatic spi_frame(input logic [31:0] word, input int nbits, input int half, input bit tail);
    cs_n = 1'b0;
    mosi = (nbits > 0) ? word[nbits-1] : 1'b0;
    wait_clks(half);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = word[i];
      wait_clks(half);
      sclk = 1'b1;
      wait_clks(half);
      sclk = 1'b0;
    end
    wait_clks(half);
    cs_n = 1'b1;
    if (tail) wait_clks(half);
  endtask

  task automatic idle_toggles(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      wait_clks(3);
      sclk = 1'b0;
      wait_clks(3);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    int          nbits;
    int          half;
    bit          good;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[8];

  int           g0;
  int           f0;
  int           o0;
  logic [W-1:0] exp_last;
  logic [W-1:0] exp_q[$];
  int           exp_ferr;

  initial begin
    vecs[0] = '{32'h0000_A5C3, 16, 8, 1'b1, 16'hA5C3};
    vecs[1] = '{32'h0000_7FFF, 15, 4, 1'b0, 16'h0000};
    vecs[2] = '{32'h0001_2345, 17, 4, 1'b0, 16'h0000};
    vecs[3] = '{32'h0000_0000,  0, 4, 1'b0, 16'h0000};
    vecs[4] = '{32'h0000_0001, 16, 3, 1'b1, 16'h0001};
    vecs[5] = '{32'h0000_FFFF, 16, 5, 1'b1, 16'hFFFF};
    vecs[6] = '{32'h000F_FFFF, 20, 3, 1'b0, 16'h0000};
    vecs[7] = '{32'h0000_8000, 16, 6, 1'b1, 16'h8000};

    PRESETn   = 1'b0;
    sclk      = 1'b0;
    cs_n      = 1'b1;
    mosi      = 1'b0;
    ready_dir = 1'b1;
    rand_en   = 1'b0;
    exp_last  = '0;
    wait_clks(3);
    check("reset rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_if.rx_data), 32'd0);
    check("reset busy", 32'(rx_if.busy), 32'd0);
    PRESETn = 1'b1;
    wait_clks(4);
    check("post-reset frame_err", 32'(rx_if.frame_err), 32'd0);
    check("post-reset overrun", 32'(rx_if.overrun), 32'd0);

    // T1: latency from cs_n rise to a one-cycle rx_valid pulse.
    f0 = ferr_cnt;
    spi_frame(32'h0000_A5C3, W, 8, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge PCLK);
      #1;
      check($sformatf("T1 rx_valid low at edge %0d", k), 32'(rx_if.rx_valid), 32'd0);
    end
    @(posedge PCLK);
    #1;
    check("T1 rx_valid at edge 4", 32'(rx_if.rx_valid), 32'd1);
    check("T1 rx_data", 32'(rx_if.rx_data), 32'h0000_A5C3);
    @(posedge PCLK);
    #1;
    check("T1 rx_valid pulse ends", 32'(rx_if.rx_valid), 32'd0);
    wait_clks(6);
    check("T1 no frame_err", 32'(ferr_cnt - f0), 32'd0);
    exp_last = 16'hA5C3;

    // Directed frame table with the consumer always ready.
    foreach (vecs[i]) begin
      g0 = got_q.size();
      f0 = ferr_cnt;
      spi_frame(vecs[i].word, vecs[i].nbits, vecs[i].half, 1'b1);
      wait_clks(6);
      check($sformatf("vec%0d delivered", i), 32'(got_q.size() - g0), 32'(vecs[i].good));
      check($sformatf("vec%0d frame_err", i), 32'(ferr_cnt - f0), 32'(!vecs[i].good));
      if (vecs[i].good) begin
        check($sformatf("vec%0d word", i), 32'(got_q[$]), 32'(vecs[i].data));
        exp_last = vecs[i].data;
      end
      check($sformatf("vec%0d rx_data", i), 32'(rx_if.rx_data), 32'(exp_last));
    end

    // T4: sclk activity with cs_n high is ignored.
    g0 = got_q.size();
    f0 = ferr_cnt;
    idle_toggles(6);
    spi_frame(32'h0000_0001, W, 4, 1'b1);
    wait_clks(6);
    check("T4 one word", 32'(got_q.size() - g0), 32'd1);
    check("T4 word", 32'(got_q[$]), 32'h0000_0001);
    check("T4 no frame_err", 32'(ferr_cnt - f0), 32'd0);

    // T2: consumer stalled across two good frames.
    ready_dir = 1'b0;
    o0 = ovr_cnt;
    g0 = got_q.size();
    spi_frame(32'h0000_1234, W, 4, 1'b1);
    spi_frame(32'h0000_FFFF, W, 4, 1'b1);
    wait_clks(6);
    check("T2 rx_valid held", 32'(rx_if.rx_valid), 32'd1);
    check("T2 rx_data kept", 32'(rx_if.rx_data), 32'h0000_1234);
    check("T2 one overrun", 32'(ovr_cnt - o0), 32'd1);
    check("T2 nothing accepted", 32'(got_q.size() - g0), 32'd0);
    ready_dir = 1'b1;
    @(posedge PCLK);
    #1;
    check("T2 rx_valid drops", 32'(rx_if.rx_valid), 32'd0);
    check("T2 accepted word", 32'(got_q[$]), 32'h0000_1234);

    // Accept and good-frame load in the same cycle: slot counts as free.
    ready_dir = 1'b0;
    o0 = ovr_cnt;
    wait_clks(2);
    spi_frame(32'h0000_1111, W, 4, 1'b1);
    spi_frame(32'h0000_2222, W, 4, 1'b0);
    repeat (3) @(negedge PCLK);
    ready_dir = 1'b1;
    @(posedge PCLK);
    #1;
    check("swap rx_valid", 32'(rx_if.rx_valid), 32'd1);
    check("swap rx_data", 32'(rx_if.rx_data), 32'h0000_2222);
    @(negedge PCLK);
    ready_dir = 1'b0;
    check("swap old word accepted", 32'(got_q[$]), 32'h0000_1111);
    wait_clks(4);
    check("swap no overrun", 32'(ovr_cnt - o0), 32'd0);
    check("swap new word held", 32'(rx_if.rx_data), 32'h0000_2222);
    ready_dir = 1'b1;
    wait_clks(2);
    check("swap new word accepted", 32'(got_q[$]), 32'h0000_2222);

    // T5: reset in the middle of a frame discards the partial word.
    f0 = ferr_cnt;
    cs_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 8; i++) begin
      mosi = 1'(i & 1);
      wait_clks(4);
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
    end
    check("T5 busy mid-frame", 32'(rx_if.busy), 32'd1);
    PRESETn = 1'b0;
    #1;
    check("T5 reset rx_data", 32'(rx_if.rx_data), 32'd0);
    check("T5 reset rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("T5 reset busy", 32'(rx_if.busy), 32'd0);
    check("T5 reset frame_err", 32'(rx_if.frame_err), 32'd0);
    check("T5 reset overrun", 32'(rx_if.overrun), 32'd0);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clks(4);
    PRESETn = 1'b1;
    wait_clks(4);
    g0 = got_q.size();
    spi_frame(32'h0000_BEEF, W, 4, 1'b1);
    wait_clks(6);
    check("T5 one word", 32'(got_q.size() - g0), 32'd1);
    check("T5 word", 32'(got_q[$]), 32'h0000_BEEF);
    check("T5 no frame_err", 32'(ferr_cnt - f0), 32'd0);

    // T6: repeated motor-speed frames at PCLK/16.
    f0 = ferr_cnt;
    g0 = got_q.size();
    for (int i = 0; i < 4; i++) spi_frame(32'h0000_0321, W, 8, 1'b1);
    wait_clks(6);
    check("T6 frame count", 32'(got_q.size() - g0), 32'd4);
    for (int i = g0; i < got_q.size(); i++)
      check($sformatf("T6 word %0d", i - g0), 32'(got_q[i]), 32'h0000_0321);
    check("T6 no frame_err", 32'(ferr_cnt - f0), 32'd0);

    // Randomized frames with a randomly stalling consumer, scored at frame level.
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    g0 = got_q.size();
    exp_ferr = 0;
    rand_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      automatic logic [31:0] word  = $urandom;
      automatic int          pick  = $urandom_range(0, 9);
      automatic int          nbits = W;
      automatic int          half  = $urandom_range(3, 6);
      if (pick >= 6) begin
        case ($urandom_range(0, 5))
          0: nbits = 0;
          1: nbits = 1;
          2: nbits = 8;
          3: nbits = W - 1;
          4: nbits = W + 1;
          default: nbits = W + 4;
        endcase
      end
      if ($urandom_range(0, 3) == 0) idle_toggles($urandom_range(1, 3));
      spi_frame(word, nbits, half, 1'b1);
      wait_clks($urandom_range(0, 5));
      if (nbits == W) exp_q.push_back(word[W-1:0]);
      else exp_ferr++;
    end
    for (int i = 0; i < 300 && (got_q.size() - g0) < exp_q.size(); i++) @(negedge PCLK);
    rand_en = 1'b0;
    wait_clks(4);
    check("rand word count", 32'(got_q.size() - g0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (g0 + i < got_q.size())
        check($sformatf("rand word %0d", i), 32'(got_q[g0 + i]), 32'(exp_q[i]));
    end
    check("rand frame_err count", 32'(ferr_cnt - f0), 32'(exp_ferr));
    check("rand no overrun", 32'(ovr_cnt - o0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

endmodule
